// File: rtl/led_matrix_scan.sv
// -----------------------------------------------------------------------------
// led_matrix_scan
//
// Display stage that row-scans an 8-row x 4-column RGB LED matrix. The four
// 24-bit column colour words are snapshotted into a 96-bit shadow once per
// frame (LOAD cycle). Rows 0..7 are then driven in order for ROW_TICKS cycles
// each. Because the drivers only ever read the shadow, a mid-frame change of
// the column inputs never tears the picture.
//
// Optional feature (compile-time macro SCAN_BLANK_EN):
//   When defined, every row is followed by BLANK_TICKS cycles with all drivers
//   off (including after row 7, before the next LOAD). row_idx holds the row
//   just driven during the blank and advances on the BLANK->DRIVE transition.
//   When undefined, rows follow each other directly and BLANK_TICKS only sizes
//   the tick counter.
//
// Ports
//   CLK_50M      in   1   system clock (50 MHz)
//   RST          in   1   synchronous, active-high reset (priority over scan_en)
//   scan_en      in   1   1 = scanning runs, 0 = display dark (state -> IDLE)
//   column_0..3  in   24  colour words; row r of column c = column_c[23-3r -: 3]
//                         bit2 = R, bit1 = G, bit0 = B
//   row_sel      out  8   one-hot, active-high row enable (bit r = row r)
//   red          out  4   red column drive   (bit c = column c)
//   green        out  4   green column drive (bit c = column c)
//   blue         out  4   blue column drive  (bit c = column c)
//   row_idx      out  3   row currently scanned
//   frame_start  out  1   one-cycle pulse during the LOAD cycle
//
// All outputs are registered. They are computed from the next state, so
// row_sel and the colour drives change together on the same clock edge.
// -----------------------------------------------------------------------------
module led_matrix_scan #(
  parameter int ROW_TICKS   = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic        CLK_50M,
  input  logic        RST,
  input  logic        scan_en,
  input  logic [23:0] column_0,
  input  logic [23:0] column_1,
  input  logic [23:0] column_2,
  input  logic [23:0] column_3,
  output logic [7:0]  row_sel,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [2:0]  row_idx,
  output logic        frame_start
);

  localparam int MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
  localparam int TICK_W    = $clog2(MAX_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
  localparam logic [TICK_W-1:0] ROW_LAST = TICK_W'(ROW_TICKS - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_TICKS - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
`ifdef SCAN_BLANK_EN
    ST_DRIVE = 2'd2,
    ST_BLANK = 2'd3
`else
    ST_DRIVE = 2'd2
`endif
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [TICK_W-1:0]   tick_r;
  logic [TICK_W-1:0]   tick_s;
  logic [2:0]          row_s;
  logic [95:0]         shadow_r;
  logic [95:0]         shadow_s;

  logic [7:0]          row_sel_s;
  logic [3:0]          red_s;
  logic [3:0]          green_s;
  logic [3:0]          blue_s;
  logic                frame_start_s;

  // Extract the 3-bit RGB triple of one row from a 24-bit column word.
  // Row 0 sits in the top bits, row 7 in the bottom bits.
  function automatic logic [2:0] row_rgb(input logic [23:0] word, input logic [2:0] row);
    logic [2:0] rgb;
    rgb = 3'b000;
    case (row)
      3'd0:    rgb = word[23:21];
      3'd1:    rgb = word[20:18];
      3'd2:    rgb = word[17:15];
      3'd3:    rgb = word[14:12];
      3'd4:    rgb = word[11:9];
      3'd5:    rgb = word[8:6];
      3'd6:    rgb = word[5:3];
      3'd7:    rgb = word[2:0];
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

  // Next-state logic: scan sequencing, tick counting, row advance, shadow capture.
  always_comb begin
    state_s  = state_r;
    tick_s   = tick_r + TICK_ONE;
    row_s    = row_idx;
    shadow_s = shadow_r;
    if (!scan_en) begin
      // Dark display; the shadow is kept but will be re-captured before use.
      state_s = ST_IDLE;
      tick_s  = '0;
      row_s   = 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_LOAD;
          tick_s  = '0;
          row_s   = 3'd0;
        end
        ST_LOAD: begin
          shadow_s = {column_3, column_2, column_1, column_0};
          state_s  = ST_DRIVE;
          tick_s   = '0;
          row_s    = 3'd0;
        end
        ST_DRIVE: begin
          if (tick_r == ROW_LAST) begin
            tick_s = '0;
`ifdef SCAN_BLANK_EN
            state_s = ST_BLANK;
`else
            if (row_idx == 3'd7) begin
              state_s = ST_LOAD;
              row_s   = 3'd0;
            end else begin
              state_s = ST_DRIVE;
              row_s   = row_idx + 3'd1;
            end
`endif
          end else begin
            state_s = ST_DRIVE;
          end
        end
`ifdef SCAN_BLANK_EN
        ST_BLANK: begin
          if (tick_r == BLANK_LAST) begin
            tick_s = '0;
            if (row_idx == 3'd7) begin
              state_s = ST_LOAD;
              row_s   = 3'd0;
            end else begin
              state_s = ST_DRIVE;
              row_s   = row_idx + 3'd1;
            end
          end else begin
            state_s = ST_BLANK;
          end
        end
`endif
        default: begin
          state_s = ST_IDLE;
          tick_s  = '0;
          row_s   = 3'd0;
        end
      endcase
    end
  end

  // Output decode from the next state so drives and row enable update together.
  always_comb begin
    row_sel_s     = 8'd0;
    red_s         = 4'd0;
    green_s       = 4'd0;
    blue_s        = 4'd0;
    frame_start_s = (state_s == ST_LOAD);
    if (state_s == ST_DRIVE) begin
      row_sel_s = 8'd1 << row_s;
      for (int c = 0; c < 4; c++) begin
        {red_s[c], green_s[c], blue_s[c]} = row_rgb(shadow_s[c*24 +: 24], row_s);
      end
    end else begin
      row_sel_s = 8'd0;
      red_s     = 4'd0;
      green_s   = 4'd0;
      blue_s    = 4'd0;
    end
  end

  // State, counter, shadow and registered outputs; RST overrides everything.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      tick_r      <= '0;
      shadow_r    <= 96'd0;
      row_idx     <= 3'd0;
      row_sel     <= 8'd0;
      red         <= 4'd0;
      green       <= 4'd0;
      blue        <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      state_r     <= state_s;
      tick_r      <= tick_s;
      shadow_r    <= shadow_s;
      row_idx     <= row_s;
      row_sel     <= row_sel_s;
      red         <= red_s;
      green       <= green_s;
      blue        <= blue_s;
      frame_start <= frame_start_s;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// -----------------------------------------------------------------------------
// Testbench for led_matrix_scan (ROW_TICKS=4, BLANK_TICKS=2).
// The stimulus process drives inputs on the falling edge, updates a
// frame-position reference model after each rising edge and pushes the
// expected output vector into a queue. A monitor pops one entry per falling
// edge and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_led_matrix_scan;

  localparam int R = 4;
`ifdef SCAN_BLANK_EN
  localparam int B = 2;
`else
  localparam int B = 0;
`endif
  localparam int SLOT  = R + B;
  localparam int FRAME = 1 + 8 * SLOT;

  logic        CLK_50M = 1'b0;
  logic        RST     = 1'b1;
  logic        scan_en = 1'b0;
  logic [23:0] column_0 = 24'd0;
  logic [23:0] column_1 = 24'd0;
  logic [23:0] column_2 = 24'd0;
  logic [23:0] column_3 = 24'd0;
  logic [7:0]  row_sel;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic [2:0]  row_idx;
  logic        frame_start;

  led_matrix_scan #(
    .ROW_TICKS   (R),
    .BLANK_TICKS (2)
  ) dut (
    .CLK_50M     (CLK_50M),
    .RST         (RST),
    .scan_en     (scan_en),
    .column_0    (column_0),
    .column_1    (column_1),
    .column_2    (column_2),
    .column_3    (column_3),
    .row_sel     (row_sel),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .row_idx     (row_idx),
    .frame_start (frame_start)
  );

  always #10 CLK_50M = ~CLK_50M;

  // Scoreboard queue and counters.
  logic [23:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state: frame position and captured snapshot.
  bit          active = 1'b0;
  int          pos    = 0;
  logic [23:0] snap [4];
  logic [23:0] pend [4];

  // Expected {row_sel, red, green, blue, row_idx, frame_start} at frame position p.
  function automatic logic [23:0] model_out(input int p);
    logic [7:0]  rs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic [2:0]  ri;
    logic        fs;
    logic [23:0] w;
    int          k;
    int          row;
    rs = 8'd0; r = 4'd0; g = 4'd0; b = 4'd0; ri = 3'd0; fs = 1'b0;
    if (p == 0) begin
      fs = 1'b1;
    end else begin
      k   = p - 1;
      row = k / SLOT;
      ri  = 3'(row);
      if ((k % SLOT) < R) begin
        rs = 8'(1 << row);
        for (int c = 0; c < 4; c++) begin
          w    = snap[c] >> (21 - 3 * row);
          r[c] = w[2];
          g[c] = w[1];
          b[c] = w[0];
        end
      end
    end
    return {rs, r, g, b, ri, fs};
  endfunction

  // Generic condition check with failure report.
  task automatic check_cond(input bit ok, input string what);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL %s @%0t", what, $time);
    end
  endtask

  // One clock of stimulus: apply inputs on the falling edge, model the rising edge.
  task automatic step(input logic rst_v, input logic en_v);
    logic [23:0] e;
    @(negedge CLK_50M);
    RST      = rst_v;
    scan_en  = en_v;
    column_0 = pend[0];
    column_1 = pend[1];
    column_2 = pend[2];
    column_3 = pend[3];
    @(posedge CLK_50M);
    if (rst_v || !en_v) begin
      active = 1'b0;
      e      = 24'd0;
    end else if (!active) begin
      active = 1'b1;
      pos    = 0;
      e      = model_out(0);
    end else begin
      if (pos == 0) begin
        snap[0] = column_0;
        snap[1] = column_1;
        snap[2] = column_2;
        snap[3] = column_3;
      end
      pos = (pos + 1) % FRAME;
      e   = model_out(pos);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs with the oldest expectation each falling edge.
  always @(negedge CLK_50M) begin
    logic [23:0] exp_v;
    logic [23:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v  = exp_q.pop_front();
      act_v  = {row_sel, red, green, blue, row_idx, frame_start};
      checks = checks + 1;
      if (act_v !== exp_v) begin
        errors = errors + 1;
        $display("FAIL scan_out @%0t: got row_sel=%b r=%b g=%b b=%b idx=%0d fs=%b, expected row_sel=%b r=%b g=%b b=%b idx=%0d fs=%b",
                 $time, act_v[23:16], act_v[15:12], act_v[11:8], act_v[7:4], act_v[3:1], act_v[0],
                 exp_v[23:16], exp_v[15:12], exp_v[11:8], exp_v[7:4], exp_v[3:1], exp_v[0]);
      end
    end
  end

  initial begin
    for (int c = 0; c < 4; c++) begin
      pend[c] = 24'd0;
      snap[c] = 24'd0;
    end

    // Reset held 3 cycles with scan_en high, then pixel-mapping pattern.
    pend[0] = 24'hE00000;
    pend[3] = 24'h000001;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    #1;
    check_cond({row_sel, red, green, blue, row_idx, frame_start} === 24'd0, "reset_state");
    for (int i = 0; i < 2 * FRAME + 3; i++) step(1'b0, 1'b1);

    // Tear-free: change column_1 while row 3 is shown.
    for (int i = 0; i < 2 * FRAME && !(active && pos == 2 + 3 * SLOT); i++) step(1'b0, 1'b1);
    check_cond(active && pos == 2 + 3 * SLOT, "wait_row3_expired");
    pend[1] = 24'hFFFFFF;
    for (int i = 0; i < 2 * FRAME + 2; i++) step(1'b0, 1'b1);

    // scan_en low for one cycle during row 5, then restart.
    for (int i = 0; i < 2 * FRAME && !(active && pos == 2 + 5 * SLOT); i++) step(1'b0, 1'b1);
    check_cond(active && pos == 2 + 5 * SLOT, "wait_row5_expired");
    step(1'b0, 1'b0);
    for (int i = 0; i < FRAME + 5; i++) step(1'b0, 1'b1);

    // RST mid-frame.
    for (int i = 0; i < 2 * FRAME && !(active && pos == 2 + 2 * SLOT); i++) step(1'b0, 1'b1);
    check_cond(active && pos == 2 + 2 * SLOT, "wait_row2_expired");
    step(1'b1, 1'b1);
    for (int i = 0; i < FRAME + 5; i++) step(1'b0, 1'b1);

    // Randomized traffic: column updates, enable drops, occasional reset.
    for (int i = 0; i < 2000; i++) begin
      logic rst_v;
      logic en_v;
      if ($urandom_range(7) == 0) pend[$urandom_range(3)] = 24'($urandom);
      rst_v = ($urandom_range(149) == 0);
      en_v  = ($urandom_range(59) != 0);
      step(rst_v, en_v);
    end

    // Let the monitor consume the last expectation.
    @(negedge CLK_50M);
    @(negedge CLK_50M);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
